// File: rtl/mcu_block_scheduler_if.sv
// Strip credit handshake and read-beat bus between the MCU block scheduler and its
// neighbours (strip writer upstream, line-buffer read port / DCT downstream).
interface mcu_block_scheduler_if #(
  parameter int SENSOR_X_SIZE = 720
);
  localparam int colW = $clog2(SENSOR_X_SIZE);

  logic            strip_ready;
  logic            strip_release;
  logic            rd_valid;
  logic            rd_hold;
  logic            rd_buf;
  logic [1:0]      rd_comp;
  logic [2:0]      rd_block;
  logic [2:0]      rd_row;
  logic [3:0]      rd_line;
  logic [colW-1:0] rd_col;
  logic            rd_last;
  logic            eof_out;
  logic            overflow;

  modport master (
    input  strip_ready, rd_hold,
    output strip_release, rd_valid, rd_buf, rd_comp, rd_block, rd_row,
           rd_line, rd_col, rd_last, eof_out, overflow
  );

  modport slave (
    output strip_ready, rd_hold,
    input  strip_release, rd_valid, rd_buf, rd_comp, rd_block, rd_row,
           rd_line, rd_col, rd_last, eof_out, overflow
  );
endinterface

// File: rtl/mcu_block_scheduler.sv
// Walks a stored 4:2:0 strip one 8-sample block row per beat in JPEG MCU order
// (Y0 Y1 Y2 Y3 Cb Cr), tracking two strip credits and flagging end of frame.
module mcu_block_scheduler #(
  parameter int SENSOR_X_SIZE = 720,
  parameter int SENSOR_Y_SIZE = 720
) (
  input logic                   clk,
  input logic                   resetn,
  mcu_block_scheduler_if.master sched
);

  localparam int mx     = SENSOR_X_SIZE / 16;
  localparam int my     = SENSOR_Y_SIZE / 16;
  localparam int mcuW   = (mx > 1) ? $clog2(mx) : 1;
  localparam int stripW = (my > 1) ? $clog2(my) : 1;
  localparam int colW   = $clog2(SENSOR_X_SIZE);

  localparam logic [mcuW-1:0]   lastMcu   = mcuW'(mx - 1);
  localparam logic [stripW-1:0] lastStrip = stripW'(my - 1);

  typedef enum logic {
    Idle,
    Run
  } stateT;

  stateT             state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [2:0]        block_q, block_d;
  logic [mcuW-1:0]   mcuX_q, mcuX_d;
  logic [stripW-1:0] stripY_q, stripY_d;
  logic [1:0]        pending_q, pending_d;
  logic              buf_q, buf_d;
  logic              release_q, release_d;
  logic              eof_q, eof_d;
  logic              overflow_q, overflow_d;

  logic beatAccept;
  logic lastBeat;
  logic lastAccept;

  always_comb begin
    lastBeat   = (row_q == 3'd7) && (block_q == 3'd5) && (mcuX_q == lastMcu);
    beatAccept = (state_q == Run) && !sched.rd_hold;
    lastAccept = beatAccept && lastBeat;
  end

  // A new strip arriving in the same cycle one is retired never overflows: the credit is swapped.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (sched.strip_ready && !lastAccept) begin
      if (pending_q == 2'd2) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 2'd1;
      end
    end else if (!sched.strip_ready && lastAccept) begin
      pending_d = pending_q - 2'd1;
    end
  end

  always_comb begin
    row_d    = row_q;
    block_d  = block_q;
    mcuX_d   = mcuX_q;
    stripY_d = stripY_q;
    buf_d    = buf_q;
    if (lastAccept) begin
      row_d    = '0;
      block_d  = '0;
      mcuX_d   = '0;
      buf_d    = ~buf_q;
      stripY_d = (stripY_q == lastStrip) ? '0 : stripY_q + 1'b1;
    end else if (beatAccept) begin
      if (row_q != 3'd7) begin
        row_d = row_q + 3'd1;
      end else begin
        row_d = '0;
        if (block_q != 3'd5) begin
          block_d = block_q + 3'd1;
        end else begin
          block_d = '0;
          mcuX_d  = mcuX_q + 1'b1;
        end
      end
    end
  end

  // Deciding on the post-update credit count lets the next strip follow the last beat with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle: if (pending_d != 2'd0) state_d = Run;
      Run:  if (lastAccept && (pending_d == 2'd0)) state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    release_d = lastAccept;
    eof_d     = lastAccept && (stripY_q == lastStrip);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= Idle;
      row_q      <= '0;
      block_q    <= '0;
      mcuX_q     <= '0;
      stripY_q   <= '0;
      pending_q  <= '0;
      buf_q      <= 1'b0;
      release_q  <= 1'b0;
      eof_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      block_q    <= block_d;
      mcuX_q     <= mcuX_d;
      stripY_q   <= stripY_d;
      pending_q  <= pending_d;
      buf_q      <= buf_d;
      release_q  <= release_d;
      eof_q      <= eof_d;
      overflow_q <= overflow_d;
    end
  end

  // Chroma blocks are 8x8 per MCU, so they index half-width columns and only the top 8 lines.
  always_comb begin
    sched.rd_valid      = (state_q == Run);
    sched.rd_buf        = buf_q;
    sched.rd_block      = block_q;
    sched.rd_row        = row_q;
    sched.rd_last       = (state_q == Run) && lastBeat;
    sched.strip_release = release_q;
    sched.eof_out       = eof_q;
    sched.overflow      = overflow_q;
    if (block_q[2]) begin
      sched.rd_comp = block_q[0] ? 2'd2 : 2'd1;
      sched.rd_line = {1'b0, row_q};
      sched.rd_col  = colW'({mcuX_q, 3'b000});
    end else begin
      sched.rd_comp = 2'd0;
      sched.rd_line = {block_q[1], row_q};
      sched.rd_col  = colW'({mcuX_q, block_q[0], 3'b000});
    end
  end

endmodule

// File: tb/tb_mcu_block_scheduler.sv
// Bench for mcu_block_scheduler: a beat-index reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mcu_block_scheduler;

  localparam int xSize      = 720;
  localparam int ySize      = 48;
  localparam int mx         = xSize / 16;
  localparam int my         = ySize / 16;
  localparam int stripBeats = 48 * mx;
  localparam int colW       = $clog2(xSize);
  localparam int fieldW     = 14 + colW;
  localparam int logDepth   = 4 * stripBeats + 64;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  mcu_block_scheduler_if #(.SENSOR_X_SIZE(xSize)) bus ();

  mcu_block_scheduler #(
    .SENSOR_X_SIZE(xSize),
    .SENSOR_Y_SIZE(ySize)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .sched(bus.master)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkOn = 1'b0;
  int cycle = 0;

  // Reference model state: position in the strip as a flat beat index and a credit count.
  bit mValid, mRelease, mEof, mOverflow, mBuf;
  int mIdx, mPending, mStripY;

  logic [fieldW-1:0] beatLog [logDepth];
  int beatCyc [logDepth];
  int logCount = 0;
  int relCount = 0;
  int relCycle = 0;
  int eofCount = 0;
  int eofCycle = 0;

  function automatic logic [fieldW-1:0] beatFields(int idx, bit b, bit isValid);
    int mcu, blk, row, line, col, comp;
    mcu = idx / 48;
    blk = (idx % 48) / 8;
    row = idx % 8;
    if (blk < 4) begin
      comp = 0;
      line = row + 8 * (blk / 2);
      col  = 16 * mcu + 8 * (blk % 2);
    end else begin
      comp = blk - 3;
      line = row;
      col  = 8 * mcu;
    end
    return {b, 2'(comp), 3'(blk), 3'(row), 4'(line), colW'(col),
            isValid && (idx == stripBeats - 1)};
  endfunction

  function automatic int packBeat(int b, int comp, int blk, int row, int line, int col, int last);
    logic [fieldW-1:0] v;
    v = {1'(b), 2'(comp), 3'(blk), 3'(row), 4'(line), colW'(col), 1'(last)};
    return int'(v);
  endfunction

  function automatic logic [fieldW-1:0] dutFields();
    return {bus.rd_buf, bus.rd_comp, bus.rd_block, bus.rd_row, bus.rd_line, bus.rd_col, bus.rd_last};
  endfunction

  function automatic int orderErrors(int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (beatLog[i] !== beatFields(i % stripBeats, bit'((i / stripBeats) % 2), 1'b1)) bad++;
    end
    return bad;
  endfunction

  // Model: outputs valid whenever a credit is held; credits saturate at two.
  always @(posedge clk) begin
    bit acc, lastAcc;
    int p;
    if (!resetn) begin
      mValid = 0; mRelease = 0; mEof = 0; mOverflow = 0; mBuf = 0;
      mIdx = 0; mPending = 0; mStripY = 0;
    end else begin
      acc      = mValid && !bus.rd_hold;
      lastAcc  = acc && (mIdx == stripBeats - 1);
      mRelease = lastAcc;
      mEof     = lastAcc && (mStripY == my - 1);
      p = mPending + int'(bus.strip_ready) - int'(lastAcc);
      if (p > 2) begin
        p = 2;
        mOverflow = 1;
      end
      mPending = p;
      if (lastAcc) begin
        mIdx = 0;
        mBuf = !mBuf;
        mStripY = (mStripY + 1) % my;
      end else if (acc) begin
        mIdx++;
      end
      mValid = (mPending > 0);
    end
  end

  always @(negedge clk) begin
    logic [fieldW+3:0] act, expv;
    cycle++;
    if (checkOn) begin
      act  = {bus.rd_valid, bus.strip_release, bus.eof_out, bus.overflow, dutFields()};
      expv = {mValid, mRelease, mEof, mOverflow, beatFields(mIdx, mBuf, mValid)};
      testsRun++;
      if (act !== expv) begin
        testsFailed++;
        $display("[TB] FAIL modelCompare cycle %0d: got %h expected %h", cycle, act, expv);
      end
      if (bus.rd_valid && !bus.rd_hold && logCount < logDepth) begin
        beatLog[logCount] = dutFields();
        beatCyc[logCount] = cycle;
        logCount++;
      end
      if (bus.strip_release) begin
        relCount++;
        relCycle = cycle;
      end
      if (bus.eof_out) begin
        eofCount++;
        eofCycle = cycle;
      end
    end
  end

  task automatic checkOutput(string name, int actual, int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(bit ready, bit hold);
    @(posedge clk);
    #1;
    bus.strip_ready = ready;
    bus.rd_hold = hold;
  endtask

  task automatic pulseReady(bit hold);
    applyStimulus(1'b1, hold);
    applyStimulus(1'b0, hold);
  endtask

  task automatic clearLog();
    logCount = 0;
    relCount = 0;
    eofCount = 0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    bus.strip_ready = 1'b0;
    bus.rd_hold = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clearLog();
  endtask

  task automatic waitBeats(int n, int budget, string name);
    int k = 0;
    while (logCount < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (logCount < n) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout: got %0d beats expected %0d", name, logCount, n);
    end
  endtask

  function automatic int allOutputs();
    return int'({bus.rd_valid, bus.strip_release, bus.eof_out, bus.overflow, dutFields()});
  endfunction

  initial begin
    int k;
    bus.strip_ready = 1'b0;
    bus.rd_hold = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOn = 1'b1;
    @(negedge clk);
    checkOutput("resetOutputs", allOutputs(), 0);

    // Single strip, no hold.
    doReset();
    pulseReady(1'b0);
    @(negedge clk);
    checkOutput("validRise", int'(bus.rd_valid), 1);
    checkOutput("firstBeat", int'(dutFields()), 0);
    waitBeats(stripBeats, stripBeats + 50, "strip1");
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("beat9Y1", int'(beatLog[8]), packBeat(0, 0, 1, 0, 0, 8, 0));
    checkOutput("beatY2line8", int'(beatLog[16]), packBeat(0, 0, 2, 0, 8, 0, 0));
    checkOutput("mcu1Cb", int'(beatLog[80]), packBeat(0, 1, 4, 0, 0, 8, 0));
    checkOutput("lastBeat", int'(beatLog[stripBeats - 1]), packBeat(0, 2, 5, 7, 7, 352, 1));
    checkOutput("beforeLast", int'(beatLog[stripBeats - 2][0]), 0);
    checkOutput("strip1Count", logCount, 2160);
    checkOutput("strip1Release", relCycle, beatCyc[stripBeats - 1] + 1);
    checkOutput("strip1RelCount", relCount, 1);
    checkOutput("strip1NoEof", eofCount, 0);
    checkOutput("strip1Idle", int'(bus.rd_valid), 0);
    checkOutput("strip1Order", orderErrors(stripBeats), 0);

    // Two strips back to back.
    doReset();
    pulseReady(1'b0);
    applyStimulus(1'b0, 1'b0);
    pulseReady(1'b0);
    waitBeats(2 * stripBeats, 2 * stripBeats + 50, "strip2");
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("b2bNoGap", beatCyc[2 * stripBeats - 1] - beatCyc[0], 2 * stripBeats - 1);
    checkOutput("b2bBuf0", int'(beatLog[stripBeats - 1][fieldW-1]), 0);
    checkOutput("b2bBuf1First", int'(beatLog[stripBeats]), packBeat(1, 0, 0, 0, 0, 0, 0));
    checkOutput("b2bRelCount", relCount, 2);
    checkOutput("b2bOrder", orderErrors(2 * stripBeats), 0);

    // Random hold over one strip.
    doReset();
    pulseReady(1'b0);
    k = 0;
    while (logCount < stripBeats && k < 4 * stripBeats) begin
      applyStimulus(1'b0, bit'($urandom_range(0, 1)));
      k++;
    end
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("holdCount", logCount, stripBeats);
    checkOutput("holdOrder", orderErrors(logCount), 0);
    checkOutput("holdRelCount", relCount, 1);

    // Full frame, then the next frame's first strip.
    doReset();
    for (int s = 0; s < my; s++) begin
      pulseReady(1'b0);
      waitBeats((s + 1) * stripBeats, stripBeats + 100, "frameStrip");
    end
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("frameEofCount", eofCount, 1);
    checkOutput("frameEofWithRelease", eofCycle, relCycle);
    checkOutput("frameRelCount", relCount, my);
    pulseReady(1'b0);
    @(negedge clk);
    checkOutput("nextFrameBuf", int'({bus.rd_valid, bus.rd_buf}), 3);
    waitBeats((my + 1) * stripBeats, stripBeats + 100, "nextFrame");
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("nextFrameNoEof", eofCount, 1);

    // Overflow with three credits requested while stalled.
    doReset();
    pulseReady(1'b1);
    pulseReady(1'b1);
    @(negedge clk);
    checkOutput("ovfAfterTwo", int'(bus.overflow), 0);
    pulseReady(1'b1);
    @(negedge clk);
    checkOutput("ovfAfterThree", int'(bus.overflow), 1);
    applyStimulus(1'b0, 1'b0);
    waitBeats(2 * stripBeats, 2 * stripBeats + 50, "ovfDrain");
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("ovfBeatCount", logCount, 2 * stripBeats);
    checkOutput("ovfRelCount", relCount, 2);
    checkOutput("ovfSticky", int'(bus.overflow), 1);
    checkOutput("ovfIdle", int'(bus.rd_valid), 0);

    // strip_ready coincident with the accepted last beat at two credits.
    doReset();
    pulseReady(1'b0);
    pulseReady(1'b0);
    k = 0;
    while (!(bus.rd_valid && bus.rd_last) && k < stripBeats + 50) begin
      applyStimulus(1'b0, 1'b0);
      k++;
    end
    checkOutput("coinFoundLast", int'(bus.rd_last), 1);
    bus.strip_ready = 1'b1;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("coinNoOverflow", int'(bus.overflow), 0);
    waitBeats(3 * stripBeats, 2 * stripBeats + 50, "coinDrain");
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("coinRelCount", relCount, 3);
    checkOutput("coinNoOverflowEnd", int'(bus.overflow), 0);

    // Reset in the middle of a strip.
    doReset();
    pulseReady(1'b0);
    waitBeats(1000, 1100, "midStrip");
    #1;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midResetOutputs", allOutputs(), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clearLog();
    pulseReady(1'b0);
    @(negedge clk);
    checkOutput("restartBeat", allOutputs(), int'({4'b1000, fieldW'(0)}));
    waitBeats(stripBeats, stripBeats + 50, "restart");
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("restartRelCount", relCount, 1);

    // Random strips and stalls against the model.
    doReset();
    repeat (6000) begin
      applyStimulus($urandom_range(0, 1499) == 0, $urandom_range(0, 9) < 3);
    end
    k = 0;
    while ((mPending > 0 || mValid) && k < 3 * stripBeats) begin
      applyStimulus(1'b0, 1'b0);
      k++;
    end
    repeat (2) applyStimulus(1'b0, 1'b0);
    checkOutput("randDrained", int'(bus.rd_valid), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
